// File: rtl/systolic_pe_mac.sv
// Systolic MAC processing element: sample * coef[tap_idx] added into a per-frame running sum; the accepted sample is forwarded to the next PE.
// Latency: handshake at edge k, out_valid/outputword after edge k+WORDLENGTH+1, x_out/x_valid after edge k; one sample per WORDLENGTH+2 cycles.
// Backpressure: in_ready is high only in IDLE, and in_valid is ignored while a product is in flight. There is no output stall.
//
// Ports:
//   clk30x, reset_n            clock and synchronous active-low reset (reset also clears the coefficient RAM)
//   inputword/in_valid/in_ready  sample input handshake
//   coef_we/coef_addr/coef_data  coefficient RAM write port; may be written in any state
//   outputword/out_valid/frame_done  running sum, update pulse, and end-of-frame pulse
//   tap_idx                    index of the next tap to be used
//   x_out/x_valid              forwarded sample and its update pulse
module systolic_pe_mac #(
  parameter int WORDLENGTH = 16,
  parameter int NTAPS      = 8,
  parameter int AW         = $clog2(NTAPS)
) (
  input  logic                  clk30x,
  input  logic                  reset_n,
  input  logic [WORDLENGTH-1:0] inputword,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  coef_we,
  input  logic [AW-1:0]         coef_addr,
  input  logic [WORDLENGTH-1:0] coef_data,
  output logic [WORDLENGTH-1:0] outputword,
  output logic                  out_valid,
  output logic                  frame_done,
  output logic [AW-1:0]         tap_idx,
  output logic [WORDLENGTH-1:0] x_out,
  output logic                  x_valid
);

  localparam int W  = WORDLENGTH;
  localparam int CW = $clog2(WORDLENGTH);

  // Saturation bounds, expressed in the two-guard-bit sum width.
  localparam logic signed [W+1:0] SUM_MAX = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [W+1:0] SUM_MIN = {3'b111, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MULT, ACC} state_t;

  state_t                state, state_nxt;
  logic [W-1:0]          coef [NTAPS];
  logic [W+1:0]          mcand;     // 2*|a|, pre-doubled so the final shift is W-1
  logic [W-1:0]          mplier;    // |b|, consumed LSB first
  logic [W+1:0]          acc;       // partial product, right-shifted each step
  logic                  neg;
  logic [CW-1:0]         bit_cnt;

  logic                  hs;
  logic                  last_tap;
  logic [W-1:0]          b_sel;
  logic [W-1:0]          a_mag;
  logic [W-1:0]          b_mag;
  logic signed [W+1:0]   p_ext;
  logic signed [W+1:0]   base_ext;
  logic signed [W+1:0]   sum_ext;
  logic [W-1:0]          sum_sat;

  // Next-state logic and the ready output.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = MULT;
      end
      MULT: if (bit_cnt == CW'(W - 1)) state_nxt = ACC;
      ACC:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign hs       = in_valid & in_ready;
  assign last_tap = (tap_idx == AW'(NTAPS - 1));
  assign b_sel    = coef[tap_idx];
  // Magnitude of the most negative value is 2^(W-1), which still fits in W unsigned bits.
  assign a_mag    = inputword[W-1] ? (~inputword + W'(1)) : inputword;
  assign b_mag    = b_sel[W-1]     ? (~b_sel + W'(1))     : b_sel;

  // Product and saturating sum. The product magnitude reaches 2^(W-1) only for (-1)*(-1).
  // The clamp below covers that case together with accumulation overflow.
  always_comb begin
    p_ext    = neg ? -$signed(acc) : $signed(acc);
    base_ext = (tap_idx == '0) ? '0 : {{2{outputword[W-1]}}, outputword};
    sum_ext  = base_ext + p_ext;
    if (sum_ext > SUM_MAX)      sum_sat = SUM_MAX[W-1:0];
    else if (sum_ext < SUM_MIN) sum_sat = SUM_MIN[W-1:0];
    else                        sum_sat = sum_ext[W-1:0];
  end

  always_ff @(posedge clk30x) begin
    if (!reset_n) begin
      state      <= IDLE;
      outputword <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      tap_idx    <= '0;
      x_out      <= '0;
      x_valid    <= 1'b0;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      neg        <= 1'b0;
      bit_cnt    <= '0;
      for (int i = 0; i < NTAPS; i++) coef[i] <= '0;
    end else begin
      state      <= state_nxt;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      x_valid    <= 1'b0;
      // Operands are captured from the pre-write RAM contents, so a same-cycle write to the same tap does not affect this sample.
      if (coef_we && (int'(coef_addr) < NTAPS)) coef[coef_addr] <= coef_data;
      case (state)
        IDLE: if (hs) begin
          mcand   <= {1'b0, a_mag, 1'b0};
          mplier  <= b_mag;
          acc     <= '0;
          neg     <= inputword[W-1] ^ b_sel[W-1];
          bit_cnt <= '0;
          x_out   <= inputword;
          x_valid <= 1'b1;
        end
        MULT: begin
          // Discarding the LSB on every step floors exactly, so after W steps acc = floor(|a|*|b| / 2^(W-1)).
          acc     <= (acc + (mplier[0] ? mcand : '0)) >> 1;
          mplier  <= mplier >> 1;
          bit_cnt <= bit_cnt + CW'(1);
        end
        ACC: begin
          outputword <= sum_sat;
          out_valid  <= 1'b1;
          frame_done <= last_tap;
          tap_idx    <= last_tap ? '0 : tap_idx + AW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_pe_mac.sv
module tb_systolic_pe_mac;
  localparam int W  = 16;
  localparam int N  = 8;
  localparam int AW = 3;

  logic          clk30x = 1'b0;
  logic          reset_n = 1'b0;
  logic [W-1:0]  inputword = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          coef_we = 1'b0;
  logic [AW-1:0] coef_addr = '0;
  logic [W-1:0]  coef_data = '0;
  logic [W-1:0]  outputword;
  logic          out_valid;
  logic          frame_done;
  logic [AW-1:0] tap_idx;
  logic [W-1:0]  x_out;
  logic          x_valid;

  systolic_pe_mac #(.WORDLENGTH(W), .NTAPS(N), .AW(AW)) dut (
    .clk30x(clk30x), .reset_n(reset_n),
    .inputword(inputword), .in_valid(in_valid), .in_ready(in_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .outputword(outputword), .out_valid(out_valid), .frame_done(frame_done),
    .tap_idx(tap_idx), .x_out(x_out), .x_valid(x_valid)
  );

  always #5 clk30x = ~clk30x;

  int cyc = 0;
  always @(posedge clk30x) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {logic [W-1:0] val; logic fd; logic [AW-1:0] tap; int cyc;} exp_t;
  typedef struct {logic [W-1:0] val; int cyc;} xexp_t;
  exp_t  oq[$];
  xexp_t xq[$];
  logic [AW-1:0] tap_m = '0;
  int last_hs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a result.
  always @(negedge clk30x) begin
    if (out_valid) begin
      if (oq.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_out_valid: got outputword 0x%0h expected no result (cycle %0d)", outputword, cyc);
      end else begin
        exp_t e;
        e = oq.pop_front();
        chk("outputword", outputword, e.val);
        chk("frame_done", frame_done, e.fd);
        chk("tap_idx_after", tap_idx, e.tap);
        chk("out_latency", cyc, e.cyc);
      end
    end else if (frame_done) begin
      checks++; failures++;
      $display("FAIL frame_done_alone: got 1 expected 0 without out_valid (cycle %0d)", cyc);
    end
    if (x_valid) begin
      if (xq.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_x_valid: got x_out 0x%0h expected no pulse (cycle %0d)", x_out, cyc);
      end else begin
        xexp_t x;
        x = xq.pop_front();
        chk("x_out", x_out, x.val);
        chk("x_latency", cyc, x.cyc);
      end
    end
  end

  // All tasks start and end on a falling edge.
  task automatic wcoef(input logic [AW-1:0] a, input logic [W-1:0] d);
    coef_we = 1'b1; coef_addr = a; coef_data = d;
    @(negedge clk30x);
    coef_we = 1'b0;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    @(negedge clk30x);
    reset_n = 1'b1;
    tap_m = '0;
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] exp_out, input logic fd,
                      input bit expect_out, input bit hold, input bit chk_gap);
    int n;
    int hs;
    n = 0;
    inputword = x;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk30x);
      n++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL handshake_timeout: got in_ready 0 expected 1 within 100 cycles");
      in_valid = 1'b0;
      return;
    end
    hs = cyc + 1;
    if (chk_gap) chk("handshake_gap", hs - last_hs, 18);
    last_hs = hs;
    xq.push_back('{x, hs});
    if (expect_out) begin
      tap_m = tap_m + AW'(1);
      oq.push_back('{exp_out, fd, tap_m, hs + 17});
    end
    @(negedge clk30x);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((oq.size() != 0 || xq.size() != 0 || !in_ready) && n < 200) begin
      @(negedge clk30x);
      n++;
    end
    chk("drain_pending", oq.size() + xq.size(), 0);
    chk("drain_in_ready", in_ready, 1);
  endtask

  logic [W-1:0] frame_exp [9] = '{16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h5000,
                                  16'h6000, 16'h7000, 16'h7FFF, 16'h1000};

  initial begin
    // Reset values
    repeat (2) @(negedge clk30x);
    chk("rst_outputword", outputword, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_x_out", x_out, 0);
    chk("rst_x_valid", x_valid, 0);
    chk("rst_tap_idx", tap_idx, 0);
    chk("rst_in_ready", in_ready, 1);
    reset_n = 1'b1;
    @(negedge clk30x);

    // Basic multiply
    wcoef(0, 16'h4000);
    send(16'h4000, 16'h2000, 0, 1, 0, 0);
    drain();

    // Reset clears state and coefficients. coef_we is ignored while in reset.
    wcoef(1, 16'h4000);
    coef_we = 1'b1; coef_addr = 2; coef_data = 16'h4000;
    pulse_reset();
    coef_we = 1'b0;
    chk("rst2_outputword", outputword, 0);
    chk("rst2_x_out", x_out, 0);
    chk("rst2_tap_idx", tap_idx, 0);
    chk("rst2_in_ready", in_ready, 1);
    send(16'h7FFF, 16'h0000, 0, 1, 0, 0);
    send(16'h4000, 16'h0000, 0, 1, 0, 0);
    send(16'h4000, 16'h0000, 0, 1, 0, 0);
    drain();

    // Sign, truncation and saturation
    pulse_reset(); wcoef(0, 16'h4000);
    send(16'hC000, 16'hE000, 0, 1, 0, 0); drain();
    pulse_reset(); wcoef(0, 16'h8000);
    send(16'h8000, 16'h7FFF, 0, 1, 0, 0); drain();
    pulse_reset(); wcoef(0, 16'h0001);
    send(16'hFFFF, 16'h0000, 0, 1, 0, 0); drain();

    // Frame accumulation with in_valid held high throughout
    pulse_reset();
    for (int i = 0; i < N; i++) wcoef(AW'(i), 16'h2000);
    for (int i = 0; i < 9; i++)
      send(16'h4000, frame_exp[i], (i == 7), 1, (i < 8), (i > 0));
    drain();
    chk("frame_tap_wrap", tap_idx, 1);

    // Positive and negative overflow
    pulse_reset(); wcoef(0, 16'h7000); wcoef(1, 16'h7000);
    send(16'h7FFF, 16'h6FFF, 0, 1, 0, 0);
    send(16'h7FFF, 16'h7FFF, 0, 1, 0, 0);
    drain();
    pulse_reset(); wcoef(0, 16'h9000); wcoef(1, 16'h9000);
    send(16'h7FFF, 16'h9001, 0, 1, 0, 0);
    send(16'h7FFF, 16'h8000, 0, 1, 0, 0);
    drain();

    // Write to coef[tap_idx] in the handshake cycle: old value used now, new value next frame
    pulse_reset(); wcoef(0, 16'h4000);
    coef_we = 1'b1; coef_addr = 0; coef_data = 16'h7FFF;
    send(16'h4000, 16'h2000, 0, 1, 0, 0);
    coef_we = 1'b0;
    for (int i = 1; i < N; i++) send(16'h4000, 16'h2000, (i == 7), 1, 0, 0);
    send(16'h4000, 16'h3FFF, 0, 1, 0, 0);
    drain();

    // Reset during MULT discards the in-flight product
    pulse_reset(); wcoef(0, 16'h4000);
    send(16'h4000, 16'h0000, 0, 0, 0, 0);
    repeat (5) @(negedge clk30x);
    pulse_reset();
    repeat (30) @(negedge clk30x);
    chk("abort_tap_idx", tap_idx, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_outputword", outputword, 0);
    send(16'h4000, 16'h0000, 0, 1, 0, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
